// File: rtl/wave_sample_feeder.sv
// Phase-accumulator ROM address generator with a 2-entry skid FIFO feeding a valid/ready sample stream.
// Build option: define WAVE_FEEDER_SIGNED_EN to emit two's-complement instead of offset-binary samples.
module wave_sample_feeder #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int PHASE_WIDTH = 16,
    parameter int FRAME_LEN   = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHASE_WIDTH-1:0] phase_step,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   busy
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PHASE_WIDTH-1:0] phase_acc;
    logic [PHASE_WIDTH-1:0] step_q;
    logic [CNT_W-1:0]       issue_idx;
    logic                   stop_req;
    logic                   in_flight;
    logic                   in_flight_last;

    logic [DATA_WIDTH-1:0]  fifo_data [2];
    logic                   fifo_last [2];
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             count;

    logic                   issue;
    logic                   frame_end;
    logic                   start_run;
    logic                   push;
    logic                   pop;
    logic [1:0]             pending;
    logic [DATA_WIDTH-1:0]  sample_in;

    assign pop       = m_valid & m_ready;
    assign push      = in_flight;
    // Slots already committed once this cycle's pop leaves; never exceeds 3.
    assign pending   = count + 2'(in_flight) - 2'(pop);
    assign frame_end = issue && (issue_idx == LAST_IDX);

`ifdef WAVE_FEEDER_SIGNED_EN
    assign sample_in = {~rom_rd_data[DATA_WIDTH-1], rom_rd_data[DATA_WIDTH-2:0]};
`else
    assign sample_in = rom_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        start_run  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    start_run  = 1'b1;
                end
            end
            RUN: begin
                issue = (pending < 2'd2);
                if (issue && (issue_idx == LAST_IDX) && (stop_req || stop)) state_next = DRAIN;
            end
            DRAIN: begin
                if ((count == 2'd0) && !in_flight) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state is updated with non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_acc      <= '0;
            step_q         <= '0;
            issue_idx      <= '0;
            stop_req       <= 1'b0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            in_flight      <= issue;
            in_flight_last <= frame_end;
            if (start_run) begin
                phase_acc <= '0;
                step_q    <= phase_step;
                issue_idx <= '0;
                stop_req  <= 1'b0;
            end else begin
                if (issue) begin
                    phase_acc <= phase_acc + step_q;
                    issue_idx <= frame_end ? '0 : issue_idx + 1'b1;
                end
                if ((state == RUN) && stop) stop_req <= 1'b1;
            end
        end
    end

    // NOTE: the two storage slots are reset because m_data shows the head slot directly and must read 0 out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= sample_in;
                fifo_last[wr_ptr] <= in_flight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rom_addr = phase_acc[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign m_valid  = (count != 2'd0);
    assign m_data   = fifo_data[rd_ptr];
    assign m_last   = m_valid & fifo_last[rd_ptr];
    assign busy     = (state != IDLE);

endmodule

// File: doc/wave_sample_feeder.md
# wave_sample_feeder

Streaming front end for the 128-point FFT datapath. It sits directly upstream of the 128×8 triangle-wave ROM:
- drives the ROM read address from a phase accumulator;
- absorbs the ROM's one-cycle read latency with a 2-entry skid FIFO;
- delivers samples on a valid/ready stream, with `m_last` marking every FRAME_LEN-th sample.

The ROM has no clock enable, so all backpressure is handled here.

## Interface
- `ADDR_WIDTH`, 7: ROM address width.
- `DATA_WIDTH`, 8: ROM data and sample width.
- `PHASE_WIDTH`, 16: phase accumulator width. Must be ≥ ADDR_WIDTH.
- `FRAME_LEN`, 128: samples per frame. Range 2..2^16.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: pulse; begins a run when IDLE.
- `stop`  in  1: pulse; ends the run at the next frame boundary.
- `phase_step`  in  PHASE_WIDTH: accumulator increment, sampled on an accepted `start`.
- `rom_addr`  out  ADDR_WIDTH: registered ROM address, equal to `phase_acc[PHASE_WIDTH-1 -: ADDR_WIDTH]`.
- `rom_rd_data`  in  DATA_WIDTH: ROM read data, valid one cycle after the address edge.
- `m_data`  out  DATA_WIDTH: output sample.
- `m_valid`  out  1: sample valid.
- `m_ready`  in  1: downstream ready.
- `m_last`  out  1: final sample of a frame; qualified by `m_valid`.
- `busy`  out  1: high in RUN and DRAIN.

## Operation
States and transitions:
- IDLE → RUN on `start`. Entering RUN:
  - `phase_acc` = 0;
  - `step_q` = `phase_step`;
  - issue count = 0;
  - stop request cleared.
- RUN → DRAIN when the FRAME_LEN-th issue of a frame occurs with the stop request set.
- DRAIN → IDLE when the FIFO is empty and nothing is in flight.
- `start` outside IDLE is ignored.

Issue rule:
- A read is issued in RUN when (FIFO occupancy + in-flight − pop_this_cycle) < 2.
- pop_this_cycle = `m_valid & m_ready`.
- On issue, `phase_acc` advances by `step_q`, modulo 2^PHASE_WIDTH. `rom_addr` follows, so the address wraps naturally.
- `rom_addr` holds its value whenever no read is issued.

Capture:
- The in-flight flag is set on the cycle after an issue.
- In that cycle `rom_rd_data` is written into the FIFO together with its last tag.
- The last tag is set when the issue index within the frame equals FRAME_LEN−1.

Stream:
- `m_valid` = FIFO non-empty.
- `m_data` and `m_last` come from the FIFO head.
- Data is never dropped or duplicated under any `m_ready` pattern.

Stop and step handling:
- A `stop` pulse in RUN is latched; a whole frame is always emitted.
- `stop` in IDLE or DRAIN is ignored.
- A `stop` on the same cycle as the final issue of a frame takes effect for that frame.
- `phase_step` = 0 repeats ROM[0] for every sample.
- The phase is continuous across frames within a run.

## Timing
Reset values (on the next edge with `rst_n` = 0, including mid-run):
- `rom_addr` = 0, `m_data` = 0, `m_valid` = 0, `m_last` = 0, `busy` = 0.
- State IDLE; FIFO and in-flight flag cleared.

Latency, counting the edge that samples `start` as edge 0:
- `rom_addr` = 0 after edge 0.
- The ROM reads at edge 1.
- The FIFO captures at edge 2.
- `m_valid` is high after edge 2.

Throughput and stall behaviour:
- With `m_ready` held high, one sample per cycle, sustained.
- With `m_ready` low, at most 2 samples are held; issue stops within one cycle.

`busy`:
- Rises after edge 0.
- Falls on the edge after the final `m_last` handshake of a stopped run.

## Configuration
- `WAVE_FEEDER_SIGNED_EN` defined: the sample is converted from offset-binary to two's complement as it enters the FIFO, i.e. `{~rom_rd_data[DATA_WIDTH-1], rom_rd_data[DATA_WIDTH-2:0]}`. For example, 0x80 becomes 0x00 and 0x00 becomes 0x80.
- Not defined: `m_data` is the raw ROM value.
- Latency and handshake behaviour are identical in both builds.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs → all outputs 0 and `busy` = 0; `start` during reset has no effect.
- Basic frame: `phase_step` = 0x0200, `m_ready` = 1, `start` → addresses 0,1,…,127, samples = ROM[0..127] on consecutive cycles, first `m_valid` after edge 2, `m_last` only on sample 127.
- Decimation and wrap: `phase_step` = 0x0400 for 2 frames → addresses 0,2,…,126,0,2,…; 256 samples; `m_last` on samples 127 and 255.
- Backpressure: random `m_ready` (50%), `phase_step` = 0x0200 → the accepted sequence is identical to the basic-frame case; `rom_addr` is stable on every non-issue cycle.
- Stop: `stop` pulse at sample 50 of frame 2 → frame 2 completes (256 total samples), `busy` falls one edge after the last handshake, `start` is accepted again afterwards.
- Reset mid-run: `rst_n` = 0 for 1 cycle at sample 70 with `m_valid` = 1 → outputs zero after that edge; the next `start` restarts from `rom_addr` 0. Both macro builds are checked: 0x80 → 0x00 (signed build) and 0x80 (raw build).
